div_unit: RTL and testbench

- Iterative multi-cycle integer divider in the EX stage, directly downstream of the ALU-control decode.
- Executes DIV/DIVU for the ALU path and returns {remainder, quotient} for the HI/LO write.
- Performs one restoring-division step per cycle and holds the pipeline with a stall signal while busy.

---
 rtl/div_unit_pkg.sv | 18 +
 rtl/div_unit_if.sv | 26 ++
 rtl/div_unit_step.sv | 23 ++
 rtl/div_unit.sv | 129 ++++++++++++
 tb/tb_div_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative integer divider.
// Optional build macro: DIV_EARLY_EXIT_EN (see div_unit.sv).
package div_unit_pkg;

    // Default operand width; quotient and remainder are each this wide.
    localparam int unsigned DIV_WIDTH = 32;

    // Controller states.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Quotient returned for a zero divisor: all ones.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX-stage decoder and the divider.
// master = decoder side, slave = divider side.
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic               start;
    logic               signed_div;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               annul;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               stall;

    modport master (
        output start, signed_div, a, b, annul,
        input  result, ready, stall
    );

    modport slave (
        input  start, signed_div, a, b, annul,
        output result, ready, stall
    );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor if the widened partial remainder reaches it.
module div_step
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] shifted;

    // The shifted value needs WIDTH+1 bits for the compare; the result is
    // always below the divisor again, so it fits back into WIDTH bits.
    always_comb begin
        shifted = {rem_i, bit_i};
        q_o     = (shifted >= {1'b0, dvs_i});
        rem_o   = WIDTH'(q_o ? (shifted - {1'b0, dvs_i}) : shifted);
    end
endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit for the EX stage: one restoring step per cycle,
// returns {remainder, quotient} and holds the pipeline while busy.
// Optional build macro: DIV_EARLY_EXIT_EN -- finish at acceptance when
// |a| < |b| (same results, shorter latency).
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    div_unit_if.slave bus
);
    localparam int unsigned          CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               qneg_q;
    logic               rneg_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   rem_d;
    logic               qbit_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               early;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .q_o   (qbit_d)
    );

    // Operand magnitudes, next quotient word and sign-corrected results.
    always_comb begin
        abs_a = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        // Dividend bits leave at the top while quotient bits enter at the
        // bottom, so after WIDTH steps this register holds the quotient.
        quo_d = {dvd_q[WIDTH-2:0], qbit_d};
        q_fix = qneg_q ? -quo_d : quo_d;
        r_fix = rneg_q ? -rem_d : rem_d;
`ifdef DIV_EARLY_EXIT_EN
        early = (abs_a < abs_b);
`else
        early = 1'b0;
`endif
    end

    // Controller: acceptance, one step per CALC cycle, one-cycle ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else if (bus.annul) begin
            state_q <= DIV_IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.start) begin
                        dvd_q  <= abs_a;
                        dvs_q  <= abs_b;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                        qneg_q <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        rneg_q <= bus.signed_div & bus.a[WIDTH-1];
                        if (bus.b == '0) begin
                            result_q <= {bus.a, {WIDTH{DIV_ZERO_Q[0]}}};
                            ready_q  <= 1'b1;
                            state_q  <= DIV_DONE;
                        end else if (early) begin
                            result_q <= {bus.a, {WIDTH{1'b0}}};
                            ready_q  <= 1'b1;
                            state_q  <= DIV_DONE;
                        end else begin
                            state_q <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_q <= {r_fix, q_fix};
                        ready_q  <= 1'b1;
                        state_q  <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    ready_q <= 1'b0;
                    state_q <= DIV_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    // Hold the pipeline while accepting or iterating; released in DONE.
    always_comb begin
        bus.stall = ((state_q == DIV_IDLE) && bus.start && !bus.annul)
                  || (state_q == DIV_CALC);
    end

    assign bus.result = result_q;
    assign bus.ready  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: fixed vectors, hand-written corner
// sequences (annul, reset, start while busy) and random operations
// against an arithmetic reference model.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(32)) bus ();
    div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Reference: {remainder, quotient} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sg) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    // Expected cycle (accept cycle = 0) in which ready is seen.
    function automatic int exp_lat(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        if (b == 32'd0) return 1;
        ma = (sg && a[31]) ? 32'd0 - a : a;
        mb = (sg && b[31]) ? 32'd0 - b : b;
`ifdef DIV_EARLY_EXIT_EN
        if (ma < mb) return 1;
`else
        if (ma == 32'd0 && mb == 32'd0) return 0;
`endif
        return 33;
    endfunction

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.annul      = 1'b0;
    endtask

    // Issue one operation starting at posedge+1 and wait for its ready.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [63:0] res);
        bit stall_bad;
        lat = -1;
        res = 'x;
        stall_bad = 0;
        bus.start = 1'b1;
        bus.signed_div = sg;
        bus.a = a;
        bus.b = b;
        for (int k = 0; k < 45; k++) begin
            #4;
            if (bus.ready === 1'b1) begin
                lat = k;
                res = bus.result;
                if (bus.stall !== 1'b0) stall_bad = 1;
            end else if (bus.stall !== 1'b1) begin
                stall_bad = 1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (lat >= 0) break;
        end
        chk("stall_profile", 64'(stall_bad), 64'd0);
        #4;
        chk("ready_one_cycle", 64'(bus.ready), 64'd0);
        @(posedge clk); #1;
    endtask

    int          lat;
    logic [63:0] res;
    int          pulses;
    int          pulse_cyc;
    logic [63:0] pulse_res;

    initial begin
        tbl[0] = '{1'b0, 32'd7,          32'd2,          {32'h1,        32'h3}};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        tbl[2] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0,        32'hFFFF_FFFF}};
        tbl[3] = '{1'b1, 32'd5,          32'd0,          {32'h5,        32'hFFFF_FFFF}};
        tbl[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0,        32'h8000_0000}};
        tbl[5] = '{1'b0, 32'd100,        32'd7,          {32'd2,        32'd14}};
        tbl[6] = '{1'b0, 32'd3,          32'd9,          {32'd3,        32'd0}};
        tbl[7] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,        32'hFFFF_FFFD}};
        tbl[8] = '{1'b0, 32'd0,          32'd5,          {32'd0,        32'd0}};
        tbl[9] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'd3}};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        #4;
        chk("reset_result", bus.result, 64'd0);
        chk("reset_ready", 64'(bus.ready), 64'd0);
        chk("reset_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fixed vectors
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].sg, tbl[i].a, tbl[i].b, lat, res);
            chk("vec_result", res, tbl[i].exp);
            chk("vec_latency", 64'(lat), 64'(exp_lat(tbl[i].sg, tbl[i].a, tbl[i].b)));
        end

        // Annul in cycle 10: no ready, idle in cycle 11, result kept
        run_op(1'b0, 32'd7, 32'd2, lat, res);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            bus.start = (k == 0);
            bus.signed_div = 1'b0;
            bus.a = 32'd1000;
            bus.b = 32'd3;
            bus.annul = (k == 10);
            #4;
            if (bus.ready === 1'b1) pulses++;
            if (k == 11) begin
                chk("annul_idle_stall", 64'(bus.stall), 64'd0);
                chk("annul_result_held", bus.result, {32'h1, 32'h3});
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        chk("annul_no_ready", 64'(pulses), 64'd0);
        run_op(1'b0, 32'd100, 32'd7, lat, res);
        chk("after_annul_result", res, {32'd2, 32'd14});
        chk("after_annul_latency", 64'(lat), 64'd33);

        // start while busy (CALC) and in DONE is ignored
        pulses = 0;
        pulse_cyc = -1;
        pulse_res = '0;
        for (int k = 0; k < 45; k++) begin
            if (k == 0) begin
                bus.start = 1'b1; bus.a = 32'd7; bus.b = 32'd2;
            end else if (k >= 3 && k <= 6) begin
                bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
            end else if (k == 33) begin
                bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd0;
            end else begin
                bus.start = 1'b0;
            end
            #4;
            if (bus.ready === 1'b1) begin
                pulses++;
                pulse_cyc = k;
                pulse_res = bus.result;
            end
            if (k == 33) chk("done_stall_low", 64'(bus.stall), 64'd0);
            @(posedge clk); #1;
        end
        idle_inputs();
        chk("busy_start_pulses", 64'(pulses), 64'd1);
        chk("busy_start_cycle", 64'(pulse_cyc), 64'd33);
        chk("busy_start_result", pulse_res, {32'h1, 32'h3});

        // Reset in cycle 20 of an operation
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            bus.start = (k == 0);
            bus.a = 32'd1000;
            bus.b = 32'd3;
            rst = (k == 20);
            #4;
            if (bus.ready === 1'b1) pulses++;
            if (k == 21) begin
                chk("rst_mid_result", bus.result, 64'd0);
                chk("rst_mid_stall", 64'(bus.stall), 64'd0);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        idle_inputs();
        chk("rst_mid_no_ready", 64'(pulses), 64'd0);

        // Random operations against the model
        for (int i = 0; i < 150; i++) begin
            logic        sg;
            logic [31:0] a;
            logic [31:0] b;
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: b = a ^ 32'h4000_0000;
                4: begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom;
            endcase
            run_op(sg, a, b, lat, res);
            chk("rand_result", res, model(sg, a, b));
            chk("rand_latency", 64'(lat), 64'(exp_lat(sg, a, b)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
